// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   N-master to 1-slave AXI read-channel arbiter. Round-robin arbitration,
//   grant held for the whole burst, one outstanding transaction at a time.
//
//   Ports
//     clk, rst          : clock, synchronous active-high reset
//     m_ar*             : per-master AR channels, master i at slice i
//     m_r*              : R channel to masters (shared data, per-master valid/ready)
//     s_ar*             : AR channel to slave, s_arid = {grant index, master ARID}
//     s_r*              : R channel from slave
//     prot_err          : one-cycle pulse after a malformed response beat
//
//   Optional: define AXI_RD_ARB_PERF_EN to add per-master saturating
//   perf_grant_cnt / perf_wait_cnt counters (32 bits per master).
module axi_rd_arbiter #(
    parameter  int NUM_M     = 2,
    parameter  int ID_BITS   = 4,
    parameter  int ADDR_BITS = 32,
    parameter  int DATA_BITS = 32,
    parameter  int LEN_BITS  = 4,
    parameter  int SIZE_BITS = 3,
    localparam int MIDX_BITS = $clog2(NUM_M)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_M*ID_BITS-1:0]       m_arid,
    input  logic [NUM_M*ADDR_BITS-1:0]     m_araddr,
    input  logic [NUM_M*LEN_BITS-1:0]      m_arlen,
    input  logic [NUM_M*SIZE_BITS-1:0]     m_arsize,
    input  logic [NUM_M*2-1:0]             m_arburst,
    input  logic [NUM_M-1:0]               m_arvalid,
    output logic [NUM_M-1:0]               m_arready,
    output logic [ID_BITS-1:0]             m_rid,
    output logic [DATA_BITS-1:0]           m_rdata,
    output logic [1:0]                     m_rresp,
    output logic                           m_rlast,
    output logic [NUM_M-1:0]               m_rvalid,
    input  logic [NUM_M-1:0]               m_rready,
    output logic [ID_BITS+MIDX_BITS-1:0]   s_arid,
    output logic [ADDR_BITS-1:0]           s_araddr,
    output logic [LEN_BITS-1:0]            s_arlen,
    output logic [SIZE_BITS-1:0]           s_arsize,
    output logic [1:0]                     s_arburst,
    output logic                           s_arvalid,
    input  logic                           s_arready,
    input  logic [ID_BITS+MIDX_BITS-1:0]   s_rid,
    input  logic [DATA_BITS-1:0]           s_rdata,
    input  logic [1:0]                     s_rresp,
    input  logic                           s_rlast,
    input  logic                           s_rvalid,
    output logic                           s_rready,
    output logic                           prot_err
`ifdef AXI_RD_ARB_PERF_EN
    ,
    output logic [NUM_M*32-1:0]            perf_grant_cnt,
    output logic [NUM_M*32-1:0]            perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e                state_q, state_d;
    logic [MIDX_BITS-1:0]  grant_q, grant_d;
    logic [MIDX_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LEN_BITS-1:0]   beat_cnt_q, beat_cnt_d;
    logic                  prot_err_q, prot_err_d;

    logic [MIDX_BITS-1:0]  pick_idx, cand;
    logic                  pick_vld;
    logic                  ar_hs, r_hs;
    logic [MIDX_BITS-1:0]  rid_midx;

    // Round-robin search starting at rr_ptr. Scanning from the far end
    // downwards lets the closest requester overwrite the others.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_ptr_q;
        cand     = rr_ptr_q;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            cand = MIDX_BITS'((int'(rr_ptr_q) + k) % NUM_M);
            if (m_arvalid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // AR fields of the granted master; only meaningful while s_arvalid.
    assign s_arid    = {grant_q, m_arid[grant_q*ID_BITS +: ID_BITS]};
    assign s_araddr  = m_araddr[grant_q*ADDR_BITS +: ADDR_BITS];
    assign s_arlen   = m_arlen[grant_q*LEN_BITS +: LEN_BITS];
    assign s_arsize  = m_arsize[grant_q*SIZE_BITS +: SIZE_BITS];
    assign s_arburst = m_arburst[grant_q*2 +: 2];

    // R payload is broadcast; only the granted master's m_rvalid qualifies it.
    assign m_rid    = s_rid[ID_BITS-1:0];
    assign m_rdata  = s_rdata;
    assign m_rresp  = s_rresp;
    assign m_rlast  = s_rlast;
    assign rid_midx = s_rid[ID_BITS +: MIDX_BITS];
    assign prot_err = prot_err_q;

    always_comb begin
        s_arvalid = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        s_rready  = 1'b0;
        case (state_q)
            ADDR: begin
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
            end
            DATA: begin
                m_rvalid[grant_q] = s_rvalid;
                s_rready          = m_rready[grant_q];
            end
            default: ;
        endcase
    end

    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid & s_rready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        prot_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    state_d    = DATA;
                    beat_cnt_d = s_arlen;
                    rr_ptr_d   = (grant_q == MIDX_BITS'(NUM_M - 1)) ? '0
                                                                    : grant_q + MIDX_BITS'(1);
                end else if (!m_arvalid[grant_q]) begin
                    // Master withdrew its request: rearbitrate, pointer untouched.
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (r_hs) begin
                    prot_err_d = (s_rlast && beat_cnt_q != '0) ||
                                 (!s_rlast && beat_cnt_q == '0) ||
                                 (rid_midx != grant_q);
                    // Hold at zero on overrun so every extra beat keeps
                    // flagging a missing last instead of wrapping.
                    if (beat_cnt_q != '0)
                        beat_cnt_d = beat_cnt_q - LEN_BITS'(1);
                    if (s_rlast)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            prot_err_q <= prot_err_d;
        end
    end

`ifdef AXI_RD_ARB_PERF_EN
    for (genvar i = 0; i < NUM_M; i++) begin : g_perf
        logic [31:0] grant_cnt_q, grant_cnt_d;
        logic [31:0] wait_cnt_q, wait_cnt_d;

        always_comb begin
            grant_cnt_d = grant_cnt_q;
            wait_cnt_d  = wait_cnt_q;
            if (m_arvalid[i] && m_arready[i] && grant_cnt_q != 32'hFFFF_FFFF)
                grant_cnt_d = grant_cnt_q + 32'd1;
            if (m_arvalid[i] && !m_arready[i] && wait_cnt_q != 32'hFFFF_FFFF)
                wait_cnt_d = wait_cnt_q + 32'd1;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                grant_cnt_q <= '0;
                wait_cnt_q  <= '0;
            end else begin
                grant_cnt_q <= grant_cnt_d;
                wait_cnt_q  <= wait_cnt_d;
            end
        end

        assign perf_grant_cnt[i*32 +: 32] = grant_cnt_q;
        assign perf_wait_cnt[i*32 +: 32]  = wait_cnt_q;
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
    localparam int NUM_M = 4;
    localparam int IDB   = 4;
    localparam int AB    = 32;
    localparam int DB    = 32;
    localparam int LB    = 4;
    localparam int SB    = 3;
    localparam int MB    = 2;
    localparam int SIDB  = IDB + MB;

    typedef struct {
        int            m;
        logic [IDB-1:0] id;
        logic [AB-1:0]  addr;
        logic [LB-1:0]  len;
        logic [SB-1:0]  size;
        logic [1:0]     burst;
    } req_t;

    typedef struct {
        logic [DB-1:0]   data;
        logic [1:0]      resp;
        logic            last;
        logic [SIDB-1:0] rid;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_M*IDB-1:0] m_arid = '0;
    logic [NUM_M*AB-1:0]  m_araddr = '0;
    logic [NUM_M*LB-1:0]  m_arlen = '0;
    logic [NUM_M*SB-1:0]  m_arsize = '0;
    logic [NUM_M*2-1:0]   m_arburst = '0;
    logic [NUM_M-1:0]     m_arvalid = '0;
    logic [NUM_M-1:0]     m_arready;
    logic [IDB-1:0]       m_rid;
    logic [DB-1:0]        m_rdata;
    logic [1:0]           m_rresp;
    logic                 m_rlast;
    logic [NUM_M-1:0]     m_rvalid;
    logic [NUM_M-1:0]     m_rready = '0;
    logic [SIDB-1:0]      s_arid;
    logic [AB-1:0]        s_araddr;
    logic [LB-1:0]        s_arlen;
    logic [SB-1:0]        s_arsize;
    logic [1:0]           s_arburst;
    logic                 s_arvalid;
    logic                 s_arready = 1'b0;
    logic [SIDB-1:0]      s_rid = '0;
    logic [DB-1:0]        s_rdata = '0;
    logic [1:0]           s_rresp = '0;
    logic                 s_rlast = 1'b0;
    logic                 s_rvalid = 1'b0;
    logic                 s_rready;
    logic                 prot_err;
`ifdef AXI_RD_ARB_PERF_EN
    logic [NUM_M*32-1:0]  perf_grant_cnt;
    logic [NUM_M*32-1:0]  perf_wait_cnt;
`endif

    axi_rd_arbiter #(
        .NUM_M(NUM_M), .ID_BITS(IDB), .ADDR_BITS(AB), .DATA_BITS(DB),
        .LEN_BITS(LB), .SIZE_BITS(SB)
    ) dut (
        .clk(clk), .rst(rst),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .prot_err(prot_err)
`ifdef AXI_RD_ARB_PERF_EN
        , .perf_grant_cnt(perf_grant_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Bench state
    int    n_chk = 0;
    int    n_fail = 0;
    req_t  mq[NUM_M][$];      // master BFM request queues
    req_t  mdl_q[NUM_M][$];   // reference-model copy of pending requests
    req_t  ar_exp[$];         // expected AR order (scoreboard)
    beat_t sbeats[$];         // slave BFM pending beats
    int    mptr = 0;          // model round-robin pointer
    req_t  cur;
    logic  in_data = 1'b0;
    int    rem = 0;
    int    beats_done = 0;
    int    prot_seen = 0;
    logic  err_pend = 1'b0;
    logic  r_popped = 1'b0;
    int    ar_mode = 2;       // 0 random, 1 low, 2 high
    int    rr_mode = 1;       // 0 random, 1 all high, 2 all low
    logic  gap_en = 1'b0;
    int    err_mode = 0;      // 0 none, 1 early last, 2 RID mismatch on first beat

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: with every request already queued, each arbitration
    // picks the first master with pending work at or after the pointer.
    task automatic model_plan();
        int pick;
        forever begin
            pick = -1;
            for (int k = 0; k < NUM_M; k++) begin
                int c;
                c = (mptr + k) % NUM_M;
                if (pick < 0 && mdl_q[c].size() > 0) pick = c;
            end
            if (pick < 0) break;
            ar_exp.push_back(mdl_q[pick].pop_front());
            mptr = (pick + 1) % NUM_M;
        end
    endtask

    task automatic issue(input int m, input logic [IDB-1:0] id, input logic [AB-1:0] addr,
                         input logic [LB-1:0] len);
        req_t r;
        r.m = m; r.id = id; r.addr = addr; r.len = len;
        r.size = SB'($urandom); r.burst = 2'($urandom);
        mq[m].push_back(r);
        mdl_q[m].push_back(r);
    endtask

    function automatic logic busy();
        logic b;
        b = in_data || (ar_exp.size() > 0) || (sbeats.size() > 0);
        for (int i = 0; i < NUM_M; i++) if (mq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy() && n < 3000) begin @(posedge clk); n++; end
        chk({tag, "_done"}, 64'(n < 3000), 64'd1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Driver: all DUT inputs change just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                m_arvalid = '0; s_arready = 1'b0; m_rready = '0; s_rvalid = 1'b0;
            end else begin
                for (int i = 0; i < NUM_M; i++) begin
                    if (mq[i].size() > 0) begin
                        m_arvalid[i] = 1'b1;
                        m_arid[i*IDB +: IDB]   = mq[i][0].id;
                        m_araddr[i*AB +: AB]   = mq[i][0].addr;
                        m_arlen[i*LB +: LB]    = mq[i][0].len;
                        m_arsize[i*SB +: SB]   = mq[i][0].size;
                        m_arburst[i*2 +: 2]    = mq[i][0].burst;
                    end else begin
                        m_arvalid[i] = 1'b0;
                    end
                end
                s_arready = (ar_mode == 0) ? 1'($urandom) : (ar_mode == 2);
                for (int i = 0; i < NUM_M; i++)
                    m_rready[i] = (rr_mode == 0) ? ($urandom_range(0, 3) != 0) : (rr_mode == 1);
                if (!(s_rvalid && !r_popped)) begin
                    if (sbeats.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                        s_rvalid = 1'b1;
                        s_rdata  = sbeats[0].data;
                        s_rresp  = sbeats[0].resp;
                        s_rlast  = sbeats[0].last;
                        s_rid    = sbeats[0].rid;
                    end else begin
                        s_rvalid = 1'b0;
                    end
                end
                r_popped = 1'b0;
            end
        end
    end

    // Monitor / scoreboard plus BFM bookkeeping, sampled on the falling edge.
    initial begin
        logic [NUM_M-1:0] e;
        req_t h;
        int   n;
        forever begin
            @(negedge clk);
            if (rst) begin
                err_pend = 1'b0;
            end else begin
                chk("prot_err", 64'(prot_err), 64'(err_pend));
                if (prot_err) prot_seen++;
                err_pend = 1'b0;

                if (s_arvalid) begin
                    chk("arvalid_in_data", 64'(in_data), 64'd0);
                    if (ar_exp.size() == 0) begin
                        chk("ar_unexpected", 64'(s_arvalid), 64'd0);
                    end else begin
                        h = ar_exp[0];
                        chk("s_arid", 64'(s_arid), 64'({MB'(h.m), h.id}));
                        chk("s_araddr", 64'(s_araddr), 64'(h.addr));
                        chk("s_arlen", 64'(s_arlen), 64'(h.len));
                        chk("s_arsize", 64'(s_arsize), 64'(h.size));
                        chk("s_arburst", 64'(s_arburst), 64'(h.burst));
                        e = '0; e[h.m] = s_arready;
                        chk("m_arready", 64'(m_arready), 64'(e));
                    end
                end else begin
                    chk("m_arready_idle", 64'(m_arready), 64'd0);
                end

                e = '0;
                if (in_data) e[cur.m] = s_rvalid;
                chk("m_rvalid", 64'(m_rvalid), 64'(e));
                chk("s_rready", 64'(s_rready), 64'(in_data ? m_rready[cur.m] : 1'b0));
                if (in_data && s_rvalid) begin
                    chk("m_rid", 64'(m_rid), 64'(cur.id));
                    chk("m_rdata", 64'(m_rdata), 64'(s_rdata));
                    chk("m_rresp", 64'(m_rresp), 64'(s_rresp));
                    chk("m_rlast", 64'(m_rlast), 64'(s_rlast));
                end

                if (in_data && s_rvalid && s_rready) begin
                    err_pend = (s_rlast && rem != 0) || (!s_rlast && rem == 0) ||
                               (int'(s_rid[SIDB-1:IDB]) != cur.m);
                    if (rem != 0) rem--;
                    beats_done++;
                    void'(sbeats.pop_front());
                    r_popped = 1'b1;
                    if (s_rlast) in_data = 1'b0;
                end

                for (int i = 0; i < NUM_M; i++)
                    if (m_arvalid[i] && m_arready[i] && mq[i].size() > 0) void'(mq[i].pop_front());

                if (s_arvalid && s_arready && ar_exp.size() > 0) begin
                    cur = ar_exp.pop_front();
                    rem = int'(cur.len);
                    in_data = 1'b1;
                    beats_done = 0;
                    n = int'(s_arlen) + 1;
                    if (err_mode == 1 && n > 2) n = 2;
                    for (int b = 0; b < n; b++) begin
                        beat_t bt;
                        bt.data = $urandom;
                        bt.resp = 2'($urandom);
                        bt.last = (b == n - 1);
                        bt.rid  = s_arid;
                        if (err_mode == 2 && b == 0) bt.rid[IDB] = ~bt.rid[IDB];
                        sbeats.push_back(bt);
                    end
                    err_mode = 0;
                end
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_m_arready"}, 64'(m_arready), 64'd0);
        chk({tag, "_m_rvalid"}, 64'(m_rvalid), 64'd0);
        chk({tag, "_s_arvalid"}, 64'(s_arvalid), 64'd0);
        chk({tag, "_s_rready"}, 64'(s_rready), 64'd0);
        chk({tag, "_prot_err"}, 64'(prot_err), 64'd0);
    endtask

    // Stimulus
    initial begin
        int p0, n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        // Contention at reset: 0,1,0,1
        for (int r = 0; r < 2; r++) begin
            issue(0, IDB'(r), 32'h100 + 32'(r), 4'd0);
            issue(1, IDB'(r + 8), 32'h200 + 32'(r), 4'd0);
        end
        model_plan();
        wait_idle("contention");

        // Single request, first-grant latency and AR backpressure
        ar_mode = 1;
        issue(1, 4'h5, 32'h0000_1000, 4'd3);
        model_plan();
        @(posedge clk);
        @(negedge clk);
        chk("latency_n", 64'(s_arvalid), 64'd0);
        @(negedge clk);
        chk("latency_n1", 64'(s_arvalid), 64'd1);
        chk("s_arid_0x15", 64'(s_arid), 64'h15);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("ar_hold_valid", 64'(s_arvalid), 64'd1);
            chk("ar_hold_addr", 64'(s_araddr), 64'h1000);
        end
        @(posedge clk); #2;
        ar_mode = 2;
        n = 0;
        while (!in_data && n < 50) begin @(posedge clk); #2; n++; end
        chk("single_in_data", 64'(in_data), 64'd1);
        rr_mode = 2;
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rready_low_s_rready", 64'(s_rready), 64'd0);
            if (sbeats.size() > 0) chk("rready_low_hold", 64'(m_rdata), 64'(sbeats[0].data));
        end
        @(posedge clk); #2;
        rr_mode = 1;
        wait_idle("single");

        // Masters 1 and 3 with pointer at 2: expect 3 then 1
        issue(1, 4'h1, 32'h3000, 4'd1);
        issue(3, 4'h3, 32'h4000, 4'd2);
        model_plan();
        wait_idle("rr_ptr2");

        // Early last
        p0 = prot_seen;
        err_mode = 1;
        issue(0, 4'hA, 32'h5000, 4'd3);
        model_plan();
        wait_idle("early_last");
        chk("early_last_pulses", 64'(prot_seen - p0), 64'd1);

        // RID mismatch
        p0 = prot_seen;
        err_mode = 2;
        issue(2, 4'hC, 32'h6000, 4'd1);
        model_plan();
        wait_idle("rid_mismatch");
        chk("rid_mismatch_pulses", 64'(prot_seen - p0), 64'd1);

        // Reset mid-burst
        issue(1, 4'h7, 32'h7000, 4'd3);
        model_plan();
        n = 0;
        while (!(in_data && beats_done >= 2) && n < 200) begin @(posedge clk); #2; n++; end
        chk("mid_burst_reached", 64'(n < 200), 64'd1);
        rst = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < NUM_M; i++) begin mq[i].delete(); mdl_q[i].delete(); end
        ar_exp.delete();
        sbeats.delete();
        in_data = 1'b0;
        mptr = 0;
        @(negedge clk);
        chk_outputs_zero("mid_reset");
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        issue(1, 4'h2, 32'h8000, 4'd0);
        issue(3, 4'h4, 32'h9000, 4'd1);
        model_plan();
        wait_idle("post_reset");

        // Randomized rounds
        ar_mode = 0; rr_mode = 0; gap_en = 1'b1;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NUM_M; i++) begin
                int cnt;
                cnt = $urandom_range(0, 2);
                for (int j = 0; j < cnt; j++)
                    issue(i, IDB'($urandom), $urandom, LB'($urandom_range(0, 5)));
            end
            model_plan();
            wait_idle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Parametrised N-master to 1-slave AXI read-channel arbiter. It generalises the fixed two-master read path of the current system interconnect to NUM_M masters. Arbitration is round-robin, and the grant is held for the whole burst. It sits between the CPU-side read masters (instruction fetch, data load, future DMA) and one SRAM wrapper slave port, and allows one outstanding transaction at a time.

Parameters:
NUM_M, 2, number of read masters (>=2); MIDX_BITS = $clog2(NUM_M)
ID_BITS, 4, master-side ARID/RID width
ADDR_BITS, 32, address width
DATA_BITS, 32, read data width
LEN_BITS, 4, ARLEN width
SIZE_BITS, 3, ARSIZE width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_arid  in  NUM_M*ID_BITS  per-master ARID, master i at slice i
m_araddr  in  NUM_M*ADDR_BITS  per-master ARADDR
m_arlen  in  NUM_M*LEN_BITS  per-master ARLEN
m_arsize  in  NUM_M*SIZE_BITS  per-master ARSIZE
m_arburst  in  NUM_M*2  per-master ARBURST
m_arvalid  in  NUM_M  per-master ARVALID
m_arready  out  NUM_M  per-master ARREADY
m_rid  out  ID_BITS  RID to masters, shared bus, qualified by m_rvalid
m_rdata  out  DATA_BITS  RDATA broadcast
m_rresp  out  2  RRESP broadcast
m_rlast  out  1  RLAST broadcast
m_rvalid  out  NUM_M  per-master RVALID
m_rready  in  NUM_M  per-master RREADY
s_arid  out  ID_BITS+MIDX_BITS  slave ARID = {grant index, master ARID}
s_araddr/s_arlen/s_arsize/s_arburst  out  ADDR_BITS/LEN_BITS/SIZE_BITS/2  forwarded from granted master
s_arvalid  out  1  slave ARVALID
s_arready  in  1  slave ARREADY
s_rid  in  ID_BITS+MIDX_BITS  slave RID
s_rdata/s_rresp/s_rlast/s_rvalid  in  DATA_BITS/2/1/1  slave R channel
s_rready  out  1  slave RREADY
prot_err  out  1  one-cycle pulse on a response protocol violation

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is synchronous and active-high. Reset is honoured in any state, including mid-burst: state returns to IDLE, rr_ptr=0, grant=0, beat_cnt=0, prot_err=0. The in-flight slave burst is abandoned.
- Reset values of outputs: all m_arready=0, m_rvalid=0, s_arvalid=0, s_rready=0.
- FSM states: IDLE, ADDR, DATA.
- IDLE: search m_arvalid starting at index rr_ptr and wrapping modulo NUM_M. The first asserted index becomes grant, registered, and the FSM moves to ADDR. No valid request means the FSM stays in IDLE. All ready/valid outputs are 0 in IDLE.
- Latency: m_arvalid seen in cycle N gives s_arvalid=1 in cycle N+1.
- ADDR: the AR fields of master grant are forwarded combinationally. s_arvalid = m_arvalid[grant]; m_arready[grant] = s_arready; other m_arready = 0.
- ADDR to DATA: on s_arvalid&&s_arready, go to DATA, set beat_cnt <= arlen of grant, and set rr_ptr <= (grant+1) mod NUM_M.
- Master withdrawal: if master grant drops arvalid before the handshake (illegal AXI), the FSM returns to IDLE and rr_ptr is unchanged.
- DATA: m_rvalid[grant] = s_rvalid; other m_rvalid = 0; s_rready = m_rready[grant]. m_rid = s_rid[ID_BITS-1:0]. rdata, rresp and rlast pass through unchanged.
- Beat counting: each R handshake decrements beat_cnt. A handshake with s_rlast=1 returns the FSM to IDLE.
- Protocol errors: prot_err pulses for one cycle, registered in the cycle after the offending beat, when any of these occur:
  - s_rlast=1 with beat_cnt!=0 (early last);
  - s_rlast=0 with beat_cnt==0 (missing last);
  - s_rid[upper MIDX_BITS] != grant.
  After an error the beat is still forwarded, and the FSM exits only on s_rlast.
- Back-to-back requests: a new arbitration cycle begins in IDLE one cycle after the last beat.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,NUM_M-1,0.
- Constraints: ARBURST and ARSIZE are not interpreted. Only one transaction is outstanding at a time.

Optional Feature:
Macro AXI_RD_ARB_PERF_EN.
- Defined: adds output ports perf_grant_cnt (NUM_M*32) and perf_wait_cnt (NUM_M*32), both cleared by rst.
  - perf_grant_cnt[i] increments on each AR handshake of master i.
  - perf_wait_cnt[i] increments every cycle m_arvalid[i]=1 while m_arready[i]=0.
  - Both counters saturate at 0xFFFF_FFFF.
- Undefined: the ports and counters are absent, with no functional difference elsewhere.

Test Plan:
- Single request: NUM_M=2, master1 ARADDR=0x0000_1000, ARLEN=3, ARID=5 -> s_arvalid in the next cycle with s_arid=0x15. Four beats are routed only to m_rvalid[1], the FSM returns to IDLE after RLAST, and rr_ptr=0.
- Contention: masters 0 and 1 assert simultaneously at reset -> grant order 0,1,0,1 over four single-beat transactions. m_arready is never high for both masters at once.
- NUM_M=4, masters 1 and 3 requesting, rr_ptr=2 -> master 3 is granted first, then master 1.
- Slave backpressure: s_arready low for 5 cycles -> s_arvalid and AR fields stay stable. Master RREADY low mid-burst -> s_rready=0 and data is held.
- Errors:
  - ARLEN=3 with s_rlast on beat 2 -> prot_err=1 for one cycle and the FSM returns to IDLE.
  - s_rid upper bit mismatching grant -> prot_err pulse.
- Reset mid-burst (beat 2 of 4) -> all outputs 0 in the next cycle, the FSM is in IDLE, and the next request from master 1 is granted from rr_ptr=0.
